// File: rtl/pwm_decoder.sv
// ---------------------------------------------------------------------------
// PwmDecoder (top module pwm_decoder)
//
// Receive side of the team's 8-bit PWM generator. Measures an incoming PWM
// waveform and reports, once per completed period, the period length and the
// high time in clk cycles. It also flags an input that has stayed high or low
// for longer than any measurable period.
//
// Parameters
//   WIDTH        generator counter width; measurements are WIDTH+1 bits wide
//                so that a full 2^WIDTH-cycle period fits
//   SYNC_STAGES  synchronizer depth on pwm_in (2 or more)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   pwm_in       asynchronous PWM input
//   period       cycles from one rising edge to the next (last full period)
//   high_count   cycles high within that period
//   valid        one-cycle pulse when period/high_count update
//   stuck_high   input held high until the period counter saturated
//   stuck_low    input held low until the period counter saturated
// ---------------------------------------------------------------------------
module pwm_decoder #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [WIDTH:0]   period,
   output logic [WIDTH:0]   high_count,
   output logic             valid,
   output logic             stuck_high,
   output logic             stuck_low
);

   localparam int              CW       = WIDTH + 1;
   localparam logic [CW-1:0]   ONE      = CW'(1);
   localparam logic [CW-1:0]   MAX      = '1;
   localparam logic [CW-1:0]   NEAR_MAX = MAX - ONE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_d;
   logic                   rise;
   logic                   fall;
   logic                   rise_q;
   logic                   fall_q;

   logic [CW-1:0]          pcnt;
   logic [CW-1:0]          hcnt;
   logic                   hit_max;

   state_t                 state;
   state_t                 state_next;
   logic                   valid_next;
   logic                   stuck_high_next;
   logic                   stuck_low_next;
   logic                   load_meas;

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   // The raw input is synchronized through a shift chain. s_d is the
   // previous-cycle copy of the synchronized level, used for edge detection.
   // The detected edges are registered once more so the counters and the FSM
   // see clean flop outputs; s_d is the level aligned with these registered
   // edges, so everything downstream runs on one consistent timeline and the
   // measured widths are unaffected by the extra stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         s_d    <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_d    <= s;
         rise_q <= rise;
         fall_q <= fall;
      end
   end

   // Period and high-time counters. A rising edge restarts both at 1 (the
   // rising-edge cycle itself is the first cycle of the new period). Between
   // rising edges the period counter runs every cycle and the high counter
   // runs only while the input is high. Both saturate instead of wrapping so
   // a stuck input can never alias onto a short period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt <= '0;
         hcnt <= '0;
      end else if (rise_q) begin
         pcnt <= ONE;
         hcnt <= ONE;
      end else begin
         if (pcnt != MAX) begin
            pcnt <= pcnt + ONE;
         end
         if (s_d && (hcnt != MAX)) begin
            hcnt <= hcnt + ONE;
         end
      end
   end

   // hit_max marks the single cycle in which the period counter steps onto
   // its saturation value. A rising edge in that cycle reloads the counter
   // instead, so it never counts as a timeout.
   assign hit_max = ~rise_q & (pcnt == NEAR_MAX);

   // FSM state and output registers. The measurement outputs only change
   // when the FSM asks for a load, so they hold their last values between
   // valid pulses and while a stuck flag is raised.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         valid      <= 1'b0;
         stuck_high <= 1'b0;
         stuck_low  <= 1'b0;
         period     <= '0;
         high_count <= '0;
      end else begin
         state      <= state_next;
         valid      <= valid_next;
         stuck_high <= stuck_high_next;
         stuck_low  <= stuck_low_next;
         if (load_meas) begin
            period     <= pcnt;
            high_count <= hcnt;
         end
      end
   end

   // Next-state and output decode.
   // IDLE waits for a reference rising edge; that edge only starts a period
   // and is never reported. HIGH waits for the falling edge, LOW waits for
   // the next rising edge, which closes the period and publishes the counter
   // values captured just before their reload. Saturation of the period
   // counter in any state raises exactly one stuck flag and falls back to
   // IDLE so the next rising edge re-arms measurement. In HIGH a falling edge
   // wins over a simultaneous timeout because the input did go low in time.
   always_comb begin
      state_next      = state;
      valid_next      = 1'b0;
      stuck_high_next = stuck_high;
      stuck_low_next  = stuck_low;
      load_meas       = 1'b0;
      case (state)
         IDLE: begin
            if (rise_q) begin
               state_next      = HIGH;
               stuck_high_next = 1'b0;
               stuck_low_next  = 1'b0;
            end else if (hit_max) begin
               stuck_high_next = s_d;
               stuck_low_next  = ~s_d;
            end
         end
         HIGH: begin
            if (fall_q) begin
               state_next = LOW;
            end else if (hit_max) begin
               state_next      = IDLE;
               stuck_high_next = 1'b1;
               stuck_low_next  = 1'b0;
            end
         end
         LOW: begin
            if (rise_q) begin
               state_next = HIGH;
               valid_next = 1'b1;
               load_meas  = 1'b1;
            end else if (hit_max) begin
               state_next      = IDLE;
               stuck_high_next = 1'b0;
               stuck_low_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_decoder
//
// Self-checking bench for pwm_decoder. Waveforms are described as lists of
// (high, low) pulse widths or as a generator (max, threshold) pair; the
// expected reports are derived from those descriptions: every rising edge
// after the first closes a period of high+low cycles with high cycles high.
// A negedge monitor collects whatever the DUT reports for comparison.
// ---------------------------------------------------------------------------
module tb_pwm_decoder;

   localparam int WIDTH       = 8;
   localparam int SYNC_STAGES = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           pwm_in;
   logic [WIDTH:0] period;
   logic [WIDTH:0] high_count;
   logic           valid;
   logic           stuck_high;
   logic           stuck_low;

   int checks   = 0;
   int failures = 0;
   int cycleCount = 0;

   int obsP[$];
   int obsH[$];
   int obsT[$];
   int highQ[$];
   int lowQ[$];
   int expP[$];
   int expH[$];

   pwm_decoder #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .period     (period),
      .high_count (high_count),
      .valid      (valid),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Free-running cycle index used to timestamp reports
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Monitor: record every report away from the active edge
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         obsP.push_back(int'(period));
         obsH.push_back(int'(high_count));
         obsT.push_back(cycleCount);
      end
   end

   // Safety net so the run always ends
   initial begin
      #5ms;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Hold pwm_in at a level for a number of sampling edges; ends 1ns after
   // a rising clock edge like every other driving task.
   task automatic applyStimulus(input logic level, input int cycles);
      pwm_in = level;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic clearObs();
      obsP.delete();
      obsH.delete();
      obsT.delete();
      expP.delete();
      expH.delete();
   endtask

   task automatic resetDut();
      pwm_in = 1'b0;
      reset  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      clearObs();
   endtask

   // Drive the pulse list in highQ/lowQ, then a short low tail so the
   // last report has left the pipeline.
   task automatic driveWave();
      for (int i = 0; i < highQ.size(); i++) begin
         applyStimulus(1'b1, highQ[i]);
         applyStimulus(1'b0, lowQ[i]);
      end
      applyStimulus(1'b0, 6);
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      pwm_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (period !== '0) begin
         failures++; $display("[TB] FAIL reset_period: got %0d expected 0", period);
      end
      checks++;
      if (high_count !== '0) begin
         failures++; $display("[TB] FAIL reset_high: got %0d expected 0", high_count);
      end
      checks++;
      if (valid !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid);
      end
      checks++;
      if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_stuck: got %b%b expected 00", stuck_high, stuck_low);
      end
   endtask

   task automatic test_basic();
      resetDut();
      highQ.delete(); lowQ.delete();
      for (int i = 0; i < 6; i++) begin
         highQ.push_back(3);
         lowQ.push_back(7);
      end
      driveWave();
      checks++;
      if (obsP.size() != 5) begin
         failures++; $display("[TB] FAIL basic_count: got %0d expected 5", obsP.size());
      end
      for (int i = 0; i < obsP.size(); i++) begin
         checks++;
         if (obsP[i] != 10 || obsH[i] != 3) begin
            failures++; $display("[TB] FAIL basic_value[%0d]: got %0d/%0d expected 10/3", i, obsP[i], obsH[i]);
         end
         if (i > 0) begin
            checks++;
            if (obsT[i] - obsT[i-1] != 10) begin
               failures++; $display("[TB] FAIL basic_spacing[%0d]: got %0d expected 10", i, obsT[i] - obsT[i-1]);
            end
         end
      end
   endtask

   // Generator model: counter runs 0..M, output high while counter < T.
   task automatic test_generator();
      int mList[5];
      int tList[5];
      mList[0] = 255; tList[0] = 128;
      mList[1] = 4;   tList[1] = 1;
      for (int k = 2; k < 5; k++) begin
         mList[k] = $urandom_range(2, 200);
         tList[k] = $urandom_range(1, mList[k]);
      end
      for (int k = 0; k < 5; k++) begin
         resetDut();
         for (int c = 0; c < 4 * (mList[k] + 1); c++) begin
            applyStimulus(((c % (mList[k] + 1)) < tList[k]) ? 1'b1 : 1'b0, 1);
         end
         applyStimulus(1'b0, 6);
         checks++;
         if (obsP.size() != 3) begin
            failures++; $display("[TB] FAIL gen_count M=%0d T=%0d: got %0d expected 3", mList[k], tList[k], obsP.size());
         end
         for (int i = 0; i < obsP.size(); i++) begin
            checks++;
            if (obsP[i] != mList[k] + 1 || obsH[i] != tList[k]) begin
               failures++;
               $display("[TB] FAIL gen_value M=%0d T=%0d: got %0d/%0d expected %0d/%0d",
                        mList[k], tList[k], obsP[i], obsH[i], mList[k] + 1, tList[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      resetDut();
      highQ.delete(); lowQ.delete();
      for (int i = 0; i < 25; i++) begin
         if (i == 5) begin
            highQ.push_back(1); lowQ.push_back(1);
         end else if (i == 10) begin
            highQ.push_back(255); lowQ.push_back(255);
         end else begin
            highQ.push_back($urandom_range(1, 60));
            lowQ.push_back($urandom_range(1, 60));
         end
      end
      for (int i = 0; i < 24; i++) begin
         expP.push_back(highQ[i] + lowQ[i]);
         expH.push_back(highQ[i]);
      end
      driveWave();
      checks++;
      if (obsP.size() != expP.size()) begin
         failures++; $display("[TB] FAIL random_count: got %0d expected %0d", obsP.size(), expP.size());
      end
      for (int i = 0; i < obsP.size() && i < expP.size(); i++) begin
         checks++;
         if (obsP[i] != expP[i] || obsH[i] != expH[i]) begin
            failures++; $display("[TB] FAIL random_value[%0d]: got %0d/%0d expected %0d/%0d", i, obsP[i], obsH[i], expP[i], expH[i]);
         end
      end
   endtask

   task automatic test_stuck_low();
      resetDut();
      applyStimulus(1'b0, 500);
      checks++;
      if (stuck_low !== 1'b0) begin
         failures++; $display("[TB] FAIL stuck_low_early: got %b expected 0", stuck_low);
      end
      applyStimulus(1'b0, 20);
      checks++;
      if (stuck_low !== 1'b1 || stuck_high !== 1'b0) begin
         failures++; $display("[TB] FAIL stuck_low_set: got hi=%b lo=%b expected hi=0 lo=1", stuck_high, stuck_low);
      end
      checks++;
      if (obsP.size() != 0) begin
         failures++; $display("[TB] FAIL stuck_low_novalid: got %0d expected 0", obsP.size());
      end
      applyStimulus(1'b1, 1);
      applyStimulus(1'b0, 19);
      checks++;
      if (stuck_low !== 1'b0) begin
         failures++; $display("[TB] FAIL stuck_low_clear: got %b expected 0", stuck_low);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1);
         applyStimulus(1'b0, 19);
      end
      checks++;
      if (obsP.size() != 4) begin
         failures++; $display("[TB] FAIL stuck_low_count: got %0d expected 4", obsP.size());
      end
      for (int i = 0; i < obsP.size(); i++) begin
         checks++;
         if (obsP[i] != 20 || obsH[i] != 1) begin
            failures++; $display("[TB] FAIL stuck_low_value[%0d]: got %0d/%0d expected 20/1", i, obsP[i], obsH[i]);
         end
      end
   endtask

   task automatic test_stuck_high();
      resetDut();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5);
         applyStimulus(1'b0, 7);
      end
      applyStimulus(1'b1, 500);
      checks++;
      if (stuck_high !== 1'b0) begin
         failures++; $display("[TB] FAIL stuck_high_early: got %b expected 0", stuck_high);
      end
      applyStimulus(1'b1, 25);
      checks++;
      if (stuck_high !== 1'b1 || stuck_low !== 1'b0) begin
         failures++; $display("[TB] FAIL stuck_high_set: got hi=%b lo=%b expected hi=1 lo=0", stuck_high, stuck_low);
      end
      checks++;
      if (period !== 9'd12 || high_count !== 9'd5) begin
         failures++; $display("[TB] FAIL stuck_high_hold: got %0d/%0d expected 12/5", period, high_count);
      end
      checks++;
      if (obsP.size() != 3) begin
         failures++; $display("[TB] FAIL stuck_high_count: got %0d expected 3", obsP.size());
      end
      applyStimulus(1'b0, 10);
      clearObs();
      highQ.delete(); lowQ.delete();
      for (int i = 0; i < 3; i++) begin
         highQ.push_back(6);
         lowQ.push_back(6);
      end
      driveWave();
      checks++;
      if (stuck_high !== 1'b0) begin
         failures++; $display("[TB] FAIL stuck_high_clear: got %b expected 0", stuck_high);
      end
      checks++;
      if (obsP.size() != 2) begin
         failures++; $display("[TB] FAIL stuck_high_recover_count: got %0d expected 2", obsP.size());
      end
      for (int i = 0; i < obsP.size(); i++) begin
         checks++;
         if (obsP[i] != 12 || obsH[i] != 6) begin
            failures++; $display("[TB] FAIL stuck_high_recover[%0d]: got %0d/%0d expected 12/6", i, obsP[i], obsH[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      resetDut();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 8);
         applyStimulus(1'b0, 8);
      end
      applyStimulus(1'b1, 4);
      checks++;
      if (period !== 9'd16 || high_count !== 9'd8) begin
         failures++; $display("[TB] FAIL midreset_before: got %0d/%0d expected 16/8", period, high_count);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (period !== '0 || high_count !== '0 || valid !== 1'b0 || stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_clear: got %0d/%0d v=%b sh=%b sl=%b expected all 0",
                  period, high_count, valid, stuck_high, stuck_low);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      clearObs();
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, 8);
      checks++;
      if (obsP.size() != 0) begin
         failures++; $display("[TB] FAIL midreset_firstrise: got %0d expected 0", obsP.size());
      end
      highQ.delete(); lowQ.delete();
      for (int i = 0; i < 3; i++) begin
         highQ.push_back(8);
         lowQ.push_back(8);
      end
      driveWave();
      checks++;
      if (obsP.size() != 3) begin
         failures++; $display("[TB] FAIL midreset_count: got %0d expected 3", obsP.size());
      end
      for (int i = 1; i < obsP.size(); i++) begin
         checks++;
         if (obsP[i] != 16 || obsH[i] != 8) begin
            failures++; $display("[TB] FAIL midreset_value[%0d]: got %0d/%0d expected 16/8", i, obsP[i], obsH[i]);
         end
      end
   endtask

   task automatic test_latency();
      logic expV;
      resetDut();
      applyStimulus(1'b0, 5);
      applyStimulus(1'b1, 3);
      applyStimulus(1'b0, 5);
      @(negedge clk);
      pwm_in = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0) begin
         failures++; $display("[TB] FAIL latency_edge0: got %b expected 0", valid);
      end
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         expV = (k == SYNC_STAGES + 1);
         checks++;
         if (valid !== expV) begin
            failures++; $display("[TB] FAIL latency_edge%0d: got %b expected %b", k, valid, expV);
         end
         if (k == SYNC_STAGES + 1) begin
            checks++;
            if (period !== 9'd8 || high_count !== 9'd3) begin
               failures++; $display("[TB] FAIL latency_value: got %0d/%0d expected 8/3", period, high_count);
            end
         end
      end
      applyStimulus(1'b0, 4);
   endtask

   initial begin
      reset  = 1'b0;
      pwm_in = 1'b0;
      test_reset();
      test_basic();
      test_generator();
      test_random();
      test_stuck_low();
      test_stuck_high();
      test_reset_mid();
      test_latency();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
Measures an incoming PWM waveform and reports, per completed period, the period length and high time in clk cycles. It is the receive side of the team's 8-bit PWM generator. It is used to loop back and self-check generated LED/servo PWM, and to read external PWM sources. It also flags inputs stuck high or stuck low, which covers threshold=0 and threshold>max on the generator.

Parameters:
WIDTH, 8, generator counter width; measurement outputs are WIDTH+1 bits so a full 2^WIDTH-cycle period fits.
SYNC_STAGES, 2, synchronizer flops on pwm_in (minimum 2).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
pwm_in  input  1  asynchronous PWM input
period  output  WIDTH+1  cycles from one rising edge to the next, last completed period
high_count  output  WIDTH+1  cycles high within that period
valid  output  1  one-cycle pulse when period/high_count update
stuck_high  output  1  input held high for the timeout
stuck_low  output  1  input held low for the timeout

Behaviour:
- Reset (reset=0, async): synchronizer and edge-history flops = 0; state=IDLE; pcnt=hcnt=0; period=high_count=0; valid=stuck_high=stuck_low=0.
- pwm_in passes through SYNC_STAGES flops to give s. The previous-cycle copy is s_d. rise = s & ~s_d; fall = ~s & s_d.
- MAX = 2^(WIDTH+1)-1 (511 at default). pcnt and hcnt saturate at MAX and never wrap.
- Counting, every cycle:
  - On rise: pcnt<=1 and hcnt<=1.
  - Otherwise: pcnt increments (saturating). hcnt increments (saturating) only while s=1.
- States:
  - IDLE (no reference rising edge yet):
    - rise -> HIGH, clear both stuck flags, no valid.
    - pcnt reaching MAX -> set stuck_high if s=1, else stuck_low; stay IDLE.
  - HIGH:
    - fall -> LOW.
    - pcnt reaching MAX -> stuck_high<=1, -> IDLE.
  - LOW:
    - rise -> period<=pcnt and high_count<=hcnt (values before the reload), valid<=1 for one cycle, -> HIGH.
    - pcnt reaching MAX -> stuck_low<=1, -> IDLE.
- The first rise after reset or after a stuck condition gives no valid; only complete periods are reported.
- period and high_count hold their values between valid pulses, including while a stuck flag is set.
- Stuck flags clear on the next rise. stuck_high and stuck_low are never both 1.
- Latency: valid is asserted SYNC_STAGES+1 clk edges after the edge that first samples pwm_in=1 (3 at default).
- Generator loopback contract: generator max=M, threshold=T with 0<T<=M gives period=M+1, high_count=T on every valid.
- Minimum measurable pulse is 1 cycle high or 1 cycle low (synchronous source). Shorter glitches are not detected.
- Reset mid-measurement: all state is discarded immediately. The first period after release is not reported.
- Registered outputs only; no combinational path from pwm_in to any output.

Test Plan:
- Synchronous PWM, 10-cycle period, 3 high, repeated 5 times -> from the 2nd rise on, valid pulses every 10 cycles with period=10, high_count=3; no valid on the first rise.
- Looped back from generator with max=255, threshold=128 -> period=256, high_count=128; max=4, threshold=1 -> period=5, high_count=1.
- pwm_in held 0 from reset release -> stuck_low=1 after 511 cycles, no valid. Then a 1-cycle high pulse each 20 cycles -> stuck_low clears on the first rise, then period=20, high_count=1.
- Generator threshold>max (constant high) after normal periods -> stuck_high=1 when pcnt reaches 511; period/high_count keep their last values; stuck_low stays 0.
- reset asserted for 1 cycle in mid-HIGH of a 16-cycle period -> all outputs 0 at once, no valid on the first post-reset rise, correct period=16 on the second.
- Latency check: single rising edge of pwm_in relative to clk -> valid exactly 3 clk edges after the sampling edge (SYNC_STAGES=2), lasting 1 cycle.
